// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous RAM between the instruction fetch and data ports; data wins by default.
// Latency: read data returns 1 cycle after grant, combinational from ram_rdata; each port holds its last read.
// Backpressure: is_if_read=0 defers fetch into a pending slot. SRAM_ARB_FAIR_EN gives pending fetches priority (data_sram_ok=0).
module sram_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_sram_en,
    input  logic [3:0]        inst_sram_we,
    input  logic [ADDR_W-1:0] inst_sram_addr,
    input  logic [31:0]       inst_sram_wdata,
    output logic [31:0]       inst_sram_rdata,
    output logic              is_if_read,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_we,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic [31:0]       data_sram_rdata,
    output logic              data_sram_ok,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {RESP_NONE, RESP_INST, RESP_DATA} resp_t;

    logic              pend_v;
    logic [ADDR_W-1:0] pend_addr;
    resp_t             resp_sel;
    logic [31:0]       inst_hold;
    logic [31:0]       data_hold;

    logic              inst_req;
    logic [ADDR_W-1:0] inst_req_addr;
    logic              inst_first;
    logic              inst_gnt;
    logic              data_gnt;

    // Instruction port is read-only; its write-side inputs are deliberately dropped.
    logic unused_inst_wr;
    assign unused_inst_wr = ^{inst_sram_we, inst_sram_wdata};

    // The newest fetch address always replaces a stale pending one.
    assign inst_req      = inst_sram_en | pend_v;
    assign inst_req_addr = inst_sram_en ? inst_sram_addr : pend_addr;

`ifdef SRAM_ARB_FAIR_EN
    assign inst_first   = pend_v;
    assign data_sram_ok = reset | ~data_sram_en | data_gnt;
`else
    assign inst_first   = 1'b0;
    assign data_sram_ok = 1'b1;
`endif

    assign inst_gnt   = ~reset & inst_req & (~data_sram_en | inst_first);
    assign data_gnt   = ~reset & data_sram_en & ~inst_gnt;
    assign is_if_read = reset | ~inst_req | inst_gnt;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'b0;
        ram_addr  = '0;
        ram_wdata = 32'b0;
        if (inst_gnt) begin
            ram_en   = 1'b1;
            ram_addr = inst_req_addr;
        end else if (data_gnt) begin
            ram_en    = 1'b1;
            ram_we    = data_sram_we;
            ram_addr  = data_sram_addr;
            ram_wdata = data_sram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_v    <= 1'b0;
            pend_addr <= '0;
            resp_sel  <= RESP_NONE;
            inst_hold <= 32'b0;
            data_hold <= 32'b0;
        end else begin
            if (resp_sel == RESP_INST) inst_hold <= ram_rdata;
            if (resp_sel == RESP_DATA) data_hold <= ram_rdata;

            if (inst_gnt) begin
                pend_v   <= 1'b0;
                resp_sel <= RESP_INST;
            end else if (data_gnt) begin
                resp_sel <= (data_sram_we == 4'b0) ? RESP_DATA : RESP_NONE;
            end else begin
                resp_sel <= RESP_NONE;
            end

            if (inst_req && !inst_gnt) begin
                pend_v    <= 1'b1;
                pend_addr <= inst_req_addr;
            end
        end
    end

    // Reset blanks the returned data even while a stale response is still selected.
    assign inst_sram_rdata = reset ? 32'b0 : (resp_sel == RESP_INST) ? ram_rdata : inst_hold;
    assign data_sram_rdata = reset ? 32'b0 : (resp_sel == RESP_DATA) ? ram_rdata : data_hold;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural synchronous RAM behind the shared port.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        is_if_read;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        data_sram_ok;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [logic [31:0]];

    sram_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata), .is_if_read(is_if_read),
        .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata), .data_sram_ok(data_sram_ok),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: byte-masked writes, registered read data.
    always @(posedge clk) begin
        logic [31:0] w;
        if (ram_en) begin
            w = mem.exists(ram_addr) ? mem[ram_addr] : 32'b0;
            if (ram_we != 4'b0) begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
                mem[ram_addr] = w;
            end else begin
                ram_rdata <= w;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; combinational checks happen mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    task automatic drive(input logic ie, input logic [31:0] ia,
                         input logic de, input logic [3:0] dwe,
                         input logic [31:0] da, input logic [31:0] dwd);
        inst_sram_en    = ie;
        inst_sram_addr  = ia;
        data_sram_en    = de;
        data_sram_we    = dwe;
        data_sram_addr  = da;
        data_sram_wdata = dwd;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        mem[32'h1c000000] = 32'h02800c0c;
        mem[32'h1c000004] = 32'h15000000;
        mem[32'h1c000008] = 32'h33334444;
        mem[32'h1c000100] = 32'h11112222;
        mem[32'h00000100] = 32'hdeadbeef;
        mem[32'h00000104] = 32'h0badf00d;
        mem[32'h00000200] = 32'h12345678;

        inst_sram_we    = 4'hf;
        inst_sram_wdata = 32'hffffffff;
        reset = 1'b1;
        drive(1'b1, 32'h1c000000, 1'b1, 4'h0, 32'h100, 32'h0);
        tick(); tick(); mid();
        check("rst_ram_en", {31'b0, ram_en}, 32'd0);
        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_is_if_read", {31'b0, is_if_read}, 32'd1);
        check("rst_data_ok", {31'b0, data_sram_ok}, 32'd1);
        check("rst_inst_rdata", inst_sram_rdata, 32'h0);
        check("rst_data_rdata", data_sram_rdata, 32'h0);
        tick();
        reset = 1'b0;
        idle();
        tick();

        // Instruction fetch alone, then hold while idle.
        drive(1'b1, 32'h1c000000, 1'b0, 4'h0, 32'h0, 32'h0);
        mid();
        check("inst_gnt", {31'b0, is_if_read}, 32'd1);
        check("inst_ram_addr", ram_addr, 32'h1c000000);
        check("inst_ram_we", {28'b0, ram_we}, 32'h0);
        tick();
        idle();
        check("inst_rdata", inst_sram_rdata, 32'h02800c0c);
        for (int i = 2; i <= 5; i++) begin
            tick();
            check($sformatf("inst_hold_n%0d", i), inst_sram_rdata, 32'h02800c0c);
        end

        // Conflict: data wins, fetch reissued from pending next cycle.
        drive(1'b1, 32'h1c000004, 1'b1, 4'h0, 32'h100, 32'h0);
        mid();
        check("conf_is_if_read", {31'b0, is_if_read}, 32'd0);
        check("conf_ram_addr", ram_addr, 32'h100);
        check("conf_data_ok", {31'b0, data_sram_ok}, 32'd1);
        tick();
        idle();
        check("conf_data_rdata", data_sram_rdata, 32'hdeadbeef);
        check("conf_inst_old", inst_sram_rdata, 32'h02800c0c);
        mid();
        check("conf_pend_en", {31'b0, ram_en}, 32'd1);
        check("conf_pend_addr", ram_addr, 32'h1c000004);
        check("conf_pend_gnt", {31'b0, is_if_read}, 32'd1);
        tick();
        check("conf_inst_rdata", inst_sram_rdata, 32'h15000000);
        check("conf_data_hold", data_sram_rdata, 32'hdeadbeef);

        // Override: newer fetch address replaces the deferred one.
        drive(1'b1, 32'h1c000008, 1'b1, 4'h0, 32'h100, 32'h0);
        tick();
        drive(1'b1, 32'h1c000100, 1'b1, 4'h0, 32'h104, 32'h0);
        mid();
        check("ovr_ram_addr_data", ram_addr, 32'h104);
        check("ovr_is_if_read", {31'b0, is_if_read}, 32'd0);
        tick();
        idle();
        mid();
        check("ovr_ram_addr_inst", ram_addr, 32'h1c000100);
        tick();
        check("ovr_inst_rdata", inst_sram_rdata, 32'h11112222);
        mid();
        check("ovr_no_stale_issue", {31'b0, ram_en}, 32'd0);
        tick();

        // Byte-masked write leaves data_sram_rdata untouched.
        drive(1'b0, 32'h0, 1'b1, 4'b0011, 32'h200, 32'haaaa5555);
        mid();
        check("wr_ram_we", {28'b0, ram_we}, 32'h3);
        check("wr_ram_wdata", ram_wdata, 32'haaaa5555);
        tick();
        idle();
        check("wr_data_unchanged", data_sram_rdata, 32'h0badf00d);
        tick();
        drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0);
        tick();
        idle();
        check("wr_readback", data_sram_rdata, 32'h12345555);
        tick();

        // Reset with a fetch pending discards it.
        drive(1'b1, 32'h1c000000, 1'b1, 4'h0, 32'h100, 32'h0);
        tick();
        idle();
        reset = 1'b1;
        mid();
        check("rstp_ram_en", {31'b0, ram_en}, 32'd0);
        check("rstp_is_if_read", {31'b0, is_if_read}, 32'd1);
        check("rstp_inst_rdata", inst_sram_rdata, 32'h0);
        check("rstp_data_rdata", data_sram_rdata, 32'h0);
        tick();
        reset = 1'b0;
        mid();
        check("post_rst_ram_en", {31'b0, ram_en}, 32'd0);
        check("post_rst_is_if_read", {31'b0, is_if_read}, 32'd1);
        check("post_rst_inst_rdata", inst_sram_rdata, 32'h0);
        check("post_rst_data_rdata", data_sram_rdata, 32'h0);
        tick();

        // Deferred fetch under a continuous data stream.
        drive(1'b1, 32'h1c000004, 1'b1, 4'h0, 32'h100, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h104, 32'h0);
        mid();
`ifdef SRAM_ARB_FAIR_EN
        check("fair_is_if_read", {31'b0, is_if_read}, 32'd1);
        check("fair_ram_addr", ram_addr, 32'h1c000004);
        check("fair_data_ok", {31'b0, data_sram_ok}, 32'd0);
        tick();
        check("fair_inst_rdata", inst_sram_rdata, 32'h15000000);
        mid();
        check("fair_data_retry", ram_addr, 32'h104);
        check("fair_data_ok2", {31'b0, data_sram_ok}, 32'd1);
        tick();
        idle();
        check("fair_data_rdata", data_sram_rdata, 32'h0badf00d);
`else
        check("strm_is_if_read", {31'b0, is_if_read}, 32'd0);
        check("strm_ram_addr", ram_addr, 32'h104);
        check("strm_data_ok", {31'b0, data_sram_ok}, 32'd1);
        tick();
        idle();
        check("strm_data_rdata", data_sram_rdata, 32'h0badf00d);
        mid();
        check("strm_pend_addr", ram_addr, 32'h1c000004);
        tick();
        check("strm_inst_rdata", inst_sram_rdata, 32'h15000000);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Memory-side responder for the fetch stage's instruction SRAM port and the execute/memory stage's data SRAM port. Both ports share one synchronous single-port RAM. The block arbitrates each cycle and reports the fetch-side grant on `is_if_read`. It returns read data with the one-cycle latency the stages expect, and holds returned data stable until the next granted access on that port.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width, all ports.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high.
- `inst_sram_en`, input, 1: instruction read request this cycle.
- `inst_sram_we`, input, 4: must be 0; any value is ignored and the access is treated as a read.
- `inst_sram_addr`, input, ADDR_W: instruction byte address.
- `inst_sram_wdata`, input, 32: ignored.
- `inst_sram_rdata`, output, 32: instruction read data.
- `is_if_read`, output, 1: 1 means the instruction request (new or pending) is granted this cycle, or none is outstanding.
- `data_sram_en`, input, 1: data access request.
- `data_sram_we`, input, 4: byte write enables; 0 means read.
- `data_sram_addr`, input, ADDR_W: data byte address.
- `data_sram_wdata`, input, 32: write data.
- `data_sram_rdata`, output, 32: data read data.
- `data_sram_ok`, output, 1: 1 means the data request is granted this cycle, or none is present.
- `ram_en`, output, 1: shared RAM enable.
- `ram_we`, output, 4: shared RAM byte write enables.
- `ram_addr`, output, ADDR_W: shared RAM address.
- `ram_wdata`, output, 32: shared RAM write data.
- `ram_rdata`, input, 32: shared RAM read data, valid the cycle after `ram_en`.

## Operation
- Outstanding instruction request:
  - A new request is `inst_sram_en`.
  - Otherwise it is the pending register (`pend_v`, `pend_addr`).
  - A new `inst_sram_en` overrides any pending address; the newest fetch address always wins, which covers redirect after branch.
- Grant (default build), one per cycle:
  - A data request beats the instruction request.
  - The instruction request is granted only when `data_sram_en`=0.
- On instruction grant:
  - RAM driven with `ram_we`=0 and the inst address.
  - `pend_v` cleared.
  - `resp_sel`<=INST.
- On data grant:
  - RAM driven with the data `we`/`addr`/`wdata`.
  - `resp_sel`<=DATA if `we`=0; on a write, `resp_sel`<=NONE.
- Deferred instruction request:
  - `pend_v`<=1 and `pend_addr`<=the request address.
  - `is_if_read`=0 that cycle.
- No request: `ram_en`=0 and `resp_sel`<=NONE.
- Response path:
  - `inst_sram_rdata` = `ram_rdata` when `resp_sel`==INST, else `inst_hold`.
  - `inst_hold`<=`ram_rdata` in that cycle.
  - Data side is identical using `data_hold`.
  - Held data persists indefinitely while the port is idle, so the fetch stage can stall with `inst_sram_en`=0 and keep a valid instruction.
- Data writes never update `data_hold`.
- Instruction requests can starve under back-to-back data traffic in the default build.

## Timing
- Read latency is 1 cycle: a request granted in cycle N has its data on `*_sram_rdata` in cycle N+1, combinational from `ram_rdata`.
- A deferred instruction request is reissued from `pend_addr` in the first cycle with no data request. Its data appears the cycle after that.
- `is_if_read` and `data_sram_ok` are combinational from the current requests and `pend_v`.
- Simultaneous new `inst_sram_en` and `pend_v`: the new address is used and the old pending address is dropped.
- While `reset` is 1, requests are ignored.
- Reset values:
  - `pend_v`=0, `pend_addr`=0, `resp_sel`=NONE, `inst_hold`=0, `data_hold`=0.
  - `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.
  - `inst_sram_rdata`=0, `data_sram_rdata`=0.
  - `is_if_read`=1, `data_sram_ok`=1.
- Reset mid-operation discards pending and in-flight responses. The first post-reset cycle returns the hold value 0.

## Configuration
- `SRAM_ARB_FAIR_EN` undefined:
  - Fixed data priority.
  - `data_sram_ok` is constant 1.
- `SRAM_ARB_FAIR_EN` defined:
  - A pending instruction request (`pend_v`=1) beats a data request.
  - The losing data request gets `data_sram_ok`=0 and is not buffered; the data master must hold it.
  - A new `inst_sram_en` without `pend_v` still loses to data.
  - Result: an instruction is delayed at most one cycle.

## Test plan
- Inst alone: RAM[0x1c000000]=0x02800c0c; `inst_sram_en`=1 at that address in cycle N -> `is_if_read`=1, `ram_addr`=0x1c000000, `inst_sram_rdata`=0x02800c0c in N+1 and it holds through N+5 with en=0.
- Conflict:
  - Stimulus: inst read at 0x1c000004 and data read at 0x100 in the same cycle N; RAM[0x100]=0xdeadbeef, RAM[0x1c000004]=0x15000000.
  - Response: `is_if_read`=0 in N; `data_sram_rdata`=0xdeadbeef in N+1; pending is issued in N+1; `inst_sram_rdata`=0x15000000 in N+2.
- Override: a deferred request at 0x1c000008, then a new `inst_sram_en` at 0x1c000100 while data is still busy -> only 0x1c000100 is issued to RAM.
- Data write: `we`=4'b0011, `wdata`=0xaaaa5555 at 0x200 over old 0x12345678; then read 0x200 -> 0x12345555, and `data_sram_rdata` is unchanged in the cycle after the write.
- Reset while pending: assert `reset` with `pend_v`=1 -> the next cycles show `ram_en`=0, `is_if_read`=1, and both rdata outputs 0.
- With `SRAM_ARB_FAIR_EN` and a continuous data stream: a deferred inst request is granted exactly one cycle later, and `data_sram_ok`=0 in that cycle.
